// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// One request outstanding at most; imem_valid returns >=1 cycle after imem_req.
interface fetch_unit_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid;

  modport master (output imem_req, imem_addr, input  imem_rdata, imem_valid);
  modport slave  (input  imem_req, imem_addr, output imem_rdata, imem_valid);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, talks to a variable-latency imem,
// and loads the IF/ID register under stall/redirect control; stops on HLT.
module fetch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF,
  parameter logic [15:0] NOP_INSTR   = 16'h0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                redirect,
  input  logic [15:0]         redirect_pc,
  fetch_unit_if.master        imem,
  output logic [15:0]         if_id_instr,
  output logic [15:0]         if_id_pc,
  output logic                if_id_valid,
  output logic                halted
);

  localparam logic [1:0] ST_ISSUE  = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic [15:0] skid_instr_q, skid_instr_d;
  logic [15:0] skid_pc_q, skid_pc_d;
  logic [15:0] ifid_instr_q, ifid_instr_d;
  logic [15:0] ifid_pc_q, ifid_pc_d;
  logic        ifid_valid_q, ifid_valid_d;

  // Request is gated by reset so nothing leaves the block while rst_n is low.
  assign imem.imem_req  = rst_n & (state_q == ST_ISSUE);
  assign imem.imem_addr = pc_q;

  assign if_id_instr = ifid_instr_q;
  assign if_id_pc    = ifid_pc_q;
  assign if_id_valid = ifid_valid_q;
  assign halted      = (state_q == ST_HALTED);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;

    if (redirect) begin
      pc_d         = redirect_pc;
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
      skid_instr_d = NOP_INSTR;
      skid_pc_d    = 16'h0000;
      case (state_q)
        ST_ISSUE: begin
          // The request going out this cycle is still owed a response; drop it.
          drop_d  = 1'b1;
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (imem.imem_valid) begin
            drop_d  = 1'b0;
            state_d = ST_ISSUE;
          end else begin
            drop_d  = 1'b1;
          end
        end
        default: begin
          drop_d  = 1'b0;
          state_d = ST_ISSUE;
        end
      endcase
    end else begin
      // Decode consumes IF/ID when not stalled; a load below overrides the bubble.
      if (!stall) begin
        ifid_valid_d = 1'b0;
        ifid_instr_d = NOP_INSTR;
      end
      case (state_q)
        ST_ISSUE: state_d = ST_WAIT;
        ST_WAIT: begin
          if (imem.imem_valid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = ST_ISSUE;
            end else if (!stall) begin
              ifid_instr_d = imem.imem_rdata;
              ifid_pc_d    = pc_q;
              ifid_valid_d = 1'b1;
              pc_d         = pc_q + 16'd2;
              state_d      = (imem.imem_rdata[15:12] == HALT_OPCODE) ? ST_HALTED : ST_ISSUE;
            end else begin
              skid_instr_d = imem.imem_rdata;
              skid_pc_d    = pc_q;
              pc_d         = pc_q + 16'd2;
              state_d      = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            ifid_instr_d = skid_instr_q;
            ifid_pc_d    = skid_pc_q;
            ifid_valid_d = 1'b1;
            state_d      = (skid_instr_q[15:12] == HALT_OPCODE) ? ST_HALTED : ST_ISSUE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ISSUE;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= 16'h0000;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= 16'h0000;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage sitting directly upstream of the branch/next-PC logic in the 16-bit pipeline. It owns the architectural fetch PC and issues requests to a variable-latency instruction memory. It loads the IF/ID pipeline register, whose PC output feeds the branch unit's pcIn. It accepts stalls from the hazard unit and redirects (taken branch/jump, register branch) from decode, and stops fetching on HLT.

Parameters:
RESET_PC, 16'h0000, fetch address after reset
HALT_OPCODE, 4'hF, instr[15:12] value that halts fetch
NOP_INSTR, 16'h0000, value driven on if_id_instr when if_id_valid=0

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
stall  input  1  hazard unit: hold IF/ID and do not accept a new instruction
redirect  input  1  decode resolved a taken branch/jump: flush and refetch
redirect_pc  input  16  target PC, valid when redirect=1
imem_req  output  1  request strobe, one cycle per request
imem_addr  output  16  request address (= fetch PC), valid with imem_req
imem_rdata  input  16  instruction word, valid with imem_valid
imem_valid  input  1  response strobe, >=1 cycle after imem_req
if_id_instr  output  16  instruction in decode
if_id_pc  output  16  PC of if_id_instr (to branch unit pcIn)
if_id_valid  output  1  IF/ID holds a real instruction
halted  output  1  fetch stopped on HLT

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=ISSUE, drop=0, skid empty, if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=0, halted=0. imem_req=0 while rst_n=0.
- States: ISSUE, WAIT, HOLD, HALTED. One request outstanding at most.
- ISSUE: imem_req=1, imem_addr=pc (combinational from state/pc). Next state WAIT. Only state asserting imem_req.
- WAIT: imem_req=0. On imem_valid with drop=0:
  - If stall=0: load if_id_instr=imem_rdata, if_id_pc=pc, if_id_valid=1, and set pc=pc+2. Go to ISSUE, or to HALTED if imem_rdata[15:12]==HALT_OPCODE.
  - If stall=1: capture rdata and pc into skid, set pc=pc+2, go to HOLD. IF/ID unchanged.
- WAIT, imem_valid with drop=1: discard data, clear drop, go to ISSUE (pc already holds redirect target).
- HOLD: when stall=0, move skid into IF/ID (valid=1) and go to ISSUE or HALTED per the HALT_OPCODE check. Otherwise hold.
- HALTED: imem_req=0 and halted=1. IF/ID behaves normally under stall; with no redirect, if_id_valid clears after the HLT instruction leaves IF/ID (stall=0).
- Stall with no fetch completing: IF/ID holds all fields. Only WAIT/HOLD progress as above.
- Redirect has priority over stall and over an arriving imem_valid, in every state:
  - pc=redirect_pc; if_id_valid=0; if_id_instr=NOP_INSTR; skid cleared; halted=0.
  - In WAIT with imem_valid=0: drop=1 and stay in WAIT.
  - In WAIT with imem_valid=1: discard the data and go to ISSUE.
  - In ISSUE, redirect in the same cycle as a request: that request becomes outstanding with drop=1 and the next state is WAIT.
  - In HOLD/HALTED: go to ISSUE.
- PC arithmetic is 16-bit modulo: 16'hFFFE+2=16'h0000. Bit 0 is not checked.
- imem_valid outside WAIT is ignored (protocol violation, no state change).
- Throughput with 1-cycle memory: one instruction per 2 cycles.

Test Plan:
- Reset, memory latency 1, imem_rdata=16'h1234: imem_req with addr 0x0000 in the first post-reset cycle; one cycle after imem_valid, if_id_instr=0x1234, if_id_pc=0x0000, if_id_valid=1; next imem_addr=0x0002.
- stall=1 held 3 cycles while the 0x0002 response (0x5678) arrives: IF/ID keeps 0x1234/0x0000, no imem_req. After stall falls: if_id_instr=0x5678, if_id_pc=0x0002, next request at 0x0004.
- Latency 3, redirect=1 with redirect_pc=0x0040 one cycle after the request: if_id_valid=0 the next cycle. The late response is discarded. The next imem_req addr=0x0040, and its data loads with if_id_pc=0x0040.
- Fetch 16'hF000 at 0x0010: halted=1 and no further imem_req for 10 cycles. redirect to 0x0100: halted=0 and imem_req at 0x0100.
- redirect_pc=0xFFFE: instruction loads with if_id_pc=0xFFFE, and the next imem_addr=0x0000.
- rst_n pulsed low mid-WAIT and mid-HOLD: all outputs return to reset values immediately (asynchronously). After release, the first request is at RESET_PC, and stale imem_valid pulses during reset are ignored.
